// File: rtl/serial_subtractor_if.sv
// Handshake and operand bus for the bit-serial subtractor.
// The master drives the request side; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         enable;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         bout;

   modport master (
      output start, a, b, bin, enable,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin, enable,
      output busy, done, diff, bout
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per enabled clock, LSB first.
// Operands are captured on an accepted start; the final borrow flags unsigned underflow.
// diff/bout hold their last completed value until the next completion or reset.
module serial_subtractor #(
   parameter int N = 4
) (
   input logic               clk,
   input logic               rst_n,
   serial_subtractor_if.slave bus
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [N-1:0]  a_sh_r;
   logic [N-1:0]  a_sh_nx_s;
   logic [N-1:0]  b_sh_r;
   logic [N-1:0]  b_sh_nx_s;
   logic [N-1:0]  res_r;
   logic [N-1:0]  res_nx_s;
   logic [N-1:0]  res_shift_s;
   logic [N-1:0]  diff_r;
   logic [N-1:0]  diff_nx_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic          br_r;
   logic          br_nx_s;
   logic          bout_r;
   logic          bout_nx_s;
   logic          busy_r;
   logic          busy_nx_s;
   logic          done_r;
   logic          done_nx_s;
   logic          d_s;
   logic          br_next_s;
   logic          accept_s;

   // One-bit full-subtractor slice on the current LSBs and the result shifted in from the MSB end
   always_comb begin
      d_s              = a_sh_r[0] ^ b_sh_r[0] ^ br_r;
      br_next_s        = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & br_r);
      res_shift_s      = res_r >> 1'b1;
      res_shift_s[N-1] = d_s;
   end

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_nx_s = state_r;
      a_sh_nx_s  = a_sh_r;
      b_sh_nx_s  = b_sh_r;
      res_nx_s   = res_r;
      cnt_nx_s   = cnt_r;
      br_nx_s    = br_r;
      diff_nx_s  = diff_r;
      bout_nx_s  = bout_r;
      busy_nx_s  = 1'b0;
      done_nx_s  = 1'b0;
      accept_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            busy_nx_s = 1'b1;
            if (bus.enable) begin
               a_sh_nx_s = a_sh_r >> 1'b1;
               b_sh_nx_s = b_sh_r >> 1'b1;
               res_nx_s  = res_shift_s;
               br_nx_s   = br_next_s;
               cnt_nx_s  = cnt_r + CW'(1);
               if (cnt_r == CW'(N - 1)) begin
                  // Last bit: publish the completed result and the final borrow
                  diff_nx_s  = res_shift_s;
                  bout_nx_s  = br_next_s;
                  done_nx_s  = 1'b1;
                  busy_nx_s  = 1'b0;
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = RUN;
               end
            end else begin
               // Stall: every register holds
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept_s = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase

      if (accept_s) begin
         // Capture operands; diff/bout deliberately untouched until completion
         a_sh_nx_s  = bus.a;
         b_sh_nx_s  = bus.b;
         br_nx_s    = bus.bin;
         res_nx_s   = '0;
         cnt_nx_s   = '0;
         busy_nx_s  = 1'b1;
         state_nx_s = RUN;
      end else begin
         accept_s = 1'b0;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         res_r   <= '0;
         cnt_r   <= '0;
         br_r    <= 1'b0;
         diff_r  <= '0;
         bout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         a_sh_r  <= a_sh_nx_s;
         b_sh_r  <= b_sh_nx_s;
         res_r   <= res_nx_s;
         cnt_r   <= cnt_nx_s;
         br_r    <= br_nx_s;
         diff_r  <= diff_nx_s;
         bout_r  <= bout_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;

endmodule
